mbtrain_seq_ctrl: RTL and testbench
===================================

# mbtrain_seq_ctrl

Sequencer for the MBTRAIN state of the LTSM. It walks the link through the MBTRAIN substates in spec order by enabling one substate wrapper at a time, such as the self-calibration wrapper. Each substate has its own wrapper, and the sequencer consumes that wrapper's test-ack. It also handles the LINKSPEED outcomes (done, speed degrade, repair), enforces a per-substate timeout, and reports done or error to the LTSM top.

## Interface
Parameters:
- TIMEOUT_CYCLES, 800000: cycles allowed per substate before error (8 ms at 100 MHz).
- MAX_RETRAIN, 3: maximum LINKSPEED-initiated loops (degrade or repair) before error.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- i_en  in  1  MBTRAIN enable from the LTSM top; level-sensitive.
- i_sub_ack  in  13  per-substate test-ack from the substate wrappers; bit index = substate index.
- i_linkspeed_result  in  2  LINKSPEED outcome, sampled with i_sub_ack[11]: 00 done, 01 degrade, 10 repair, 11 fail.
- o_sub_en  out  13  one-hot (or zero) enable to the substate wrappers.
- o_substate  out  4  index of the current or last substate (debug).
- o_done  out  1  MBTRAIN completed; held until i_en falls.
- o_error  out  1  MBTRAIN failed (timeout, fail result, retrain limit); held until i_en falls.

## Operation
- Substate indices 0–12: VALVREF, DATAVREF, SPEEDIDLE, TXSELFCAL, RXCLKCAL, VALTRAINCENTER, VALTRAINVREF, DATATRAINCENTER1, DATATRAINVREF, RXDESKEW, DATATRAINCENTER2, LINKSPEED, REPAIR.
- FSM states:
  - IDLE: all outputs 0.
  - ACTIVE: o_sub_en[idx]=1.
  - GAP: all enables 0 for exactly one cycle.
  - DONE
  - ERROR
- IDLE→ACTIVE (idx=0, retrain count=0) when i_en=1.
- ACTIVE with i_sub_ack[idx]=1 → GAP. Next idx:
  - idx 0–10: idx+1.
  - idx 12 (REPAIR): 3 (TXSELFCAL).
  - idx 11 (LINKSPEED), by i_linkspeed_result:
    - 00: go to DONE instead of GAP.
    - 01: next idx=2; retrain count +1.
    - 10: next idx=12; retrain count +1.
    - 11: go to ERROR.
- If an increment would exceed MAX_RETRAIN → ERROR.
- Ack bits other than idx are ignored.
- GAP→ACTIVE on the next idx after one cycle. The gap lets wrappers see their enable fall and reset internally.
- i_en=0 in any state → IDLE on the next edge. All outputs clear and counters reset; there is no completion of an in-flight substate.
- DONE and ERROR are sticky until i_en=0.
- Retrain counter width: $clog2(MAX_RETRAIN+1); it saturates and never wraps.

## Timing
- Reset values: o_sub_en=0, o_substate=0, o_done=0, o_error=0, FSM=IDLE, counters=0.
- All outputs are registered.
- i_en rising seen at edge N → o_sub_en[0]=1 after edge N.
- Ack high at edge T → enable low after T, next enable high after T+1 (one-cycle gap).
- o_done / o_error rise the cycle after the deciding ack or timeout.
- Ack and timeout expiry in the same cycle: ack wins.
- Timeout counter clears on every ACTIVE entry. It counts cycles in ACTIVE; reaching TIMEOUT_CYCLES-1 without ack → ERROR.
- Counter width is $clog2(TIMEOUT_CYCLES).

## Configuration
- MBTRAIN_TIMEOUT_EN defined: the timeout counter is instantiated and expiry → ERROR.
- MBTRAIN_TIMEOUT_EN undefined: no counter, a substate waits indefinitely, and o_error comes only from a fail result or the retrain limit.

## Structure
- Shared package mbtrain_pkg:
  - substate index localparams (SUB_VALVREF … SUB_REPAIR)
  - NUM_SUBSTATES=13
  - LINKSPEED result codes (LS_DONE, LS_DEGRADE, LS_REPAIR, LS_FAIL)
  - FSM state typedef
- One sub-module, mbtrain_timeout_cnt, with ports clk, rst, i_clear, i_count, o_expired.
  - Instantiated only under MBTRAIN_TIMEOUT_EN.

## Test plan
Bench parameters unless stated: TIMEOUT_CYCLES=16, MAX_RETRAIN=3.
- Nominal pass: i_en=1, ack each enabled substate 3 cycles after its enable, LINKSPEED result 00 → o_sub_en sequence 0x001,0x002,…,0x800 with one all-zero cycle between each; o_done=1 one cycle after LINKSPEED ack.
- Speed degrade loop: LINKSPEED result 01 → GAP, then o_sub_en=0x004 (SPEEDIDLE); on the second pass result 00 → o_done=1.
- Repair and retrain limit: result 10 → o_sub_en=0x1000, then after REPAIR ack o_sub_en=0x008. Four consecutive degrade/repair results → o_error=1 with o_done=0.
- Timeout, macro defined: enable substate 4 and never ack → o_error=1 at enable+16 cycles. Ack on cycle 15 together with expiry → advances, no error. Macro undefined → o_error stays 0 after 1000 cycles.
- Abort: drop i_en while o_sub_en=0x080 → the next cycle all outputs 0. Re-raise i_en → restarts at o_sub_en=0x001 with the retrain count cleared.
- Reset mid-run: assert rst asynchronously during ACTIVE idx=6 → outputs 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/mbtrain_pkg.sv
// mbtrain_pkg: shared substate indices, LINKSPEED result codes and FSM state type for MBTRAIN.
package mbtrain_pkg;
  localparam int NUM_SUBSTATES = 13;
  localparam logic [3:0] SUB_VALVREF = 4'd0;
  localparam logic [3:0] SUB_DATAVREF = 4'd1;
  localparam logic [3:0] SUB_SPEEDIDLE = 4'd2;
  localparam logic [3:0] SUB_TXSELFCAL = 4'd3;
  localparam logic [3:0] SUB_RXCLKCAL = 4'd4;
  localparam logic [3:0] SUB_VALTRAINCENTER = 4'd5;
  localparam logic [3:0] SUB_VALTRAINVREF = 4'd6;
  localparam logic [3:0] SUB_DATATRAINCENTER1 = 4'd7;
  localparam logic [3:0] SUB_DATATRAINVREF = 4'd8;
  localparam logic [3:0] SUB_RXDESKEW = 4'd9;
  localparam logic [3:0] SUB_DATATRAINCENTER2 = 4'd10;
  localparam logic [3:0] SUB_LINKSPEED = 4'd11;
  localparam logic [3:0] SUB_REPAIR = 4'd12;
  localparam logic [1:0] LS_DONE = 2'b00;
  localparam logic [1:0] LS_DEGRADE = 2'b01;
  localparam logic [1:0] LS_REPAIR = 2'b10;
  localparam logic [1:0] LS_FAIL = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_ACTIVE, ST_GAP, ST_DONE, ST_ERROR} state_e;
endpackage

// File: rtl/mbtrain_timeout_cnt.sv
// mbtrain_timeout_cnt: per-substate cycle counter; o_expired once TIMEOUT_CYCLES-1 cycles are counted.
module mbtrain_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign o_expired = cnt_q == LAST;
  always_comb cnt_d = i_clear ? '0 : (i_count && !o_expired) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mbtrain_seq_ctrl.sv
// mbtrain_seq_ctrl: walks the MBTRAIN substates one wrapper at a time, handling LINKSPEED outcomes.
// Define MBTRAIN_TIMEOUT_EN to add the per-substate timeout; otherwise a substate waits indefinitely.
module mbtrain_seq_ctrl
  import mbtrain_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int MAX_RETRAIN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic [12:0] i_sub_ack,
  input  logic [1:0] i_linkspeed_result,
  output logic [12:0] o_sub_en,
  output logic [3:0] o_substate,
  output logic o_done,
  output logic o_error
);
  localparam int RW = $clog2(MAX_RETRAIN + 1);
  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [NUM_SUBSTATES-1:0] sub_en_q, sub_en_d;
  logic done_q, done_d, error_q, error_d;
  logic expired;
`ifdef MBTRAIN_TIMEOUT_EN
  mbtrain_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst(rst),
    .i_clear(state_q != ST_ACTIVE),
    .i_count(state_q == ST_ACTIVE),
    .o_expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rt_d = rt_q;
    if (!i_en) begin
      state_d = ST_IDLE;
      idx_d = '0;
      rt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACTIVE;
          idx_d = SUB_VALVREF;
          rt_d = '0;
        end
        ST_ACTIVE:
          if (i_sub_ack[idx_q]) begin
            if (idx_q != SUB_LINKSPEED) begin
              state_d = ST_GAP;
              idx_d = (idx_q == SUB_REPAIR) ? SUB_TXSELFCAL : idx_q + 4'd1;
            end else if (i_linkspeed_result == LS_DONE) state_d = ST_DONE;
            else if (i_linkspeed_result == LS_FAIL || rt_q == RW'(MAX_RETRAIN)) state_d = ST_ERROR;
            else begin
              state_d = ST_GAP;
              rt_d = rt_q + RW'(1);
              idx_d = (i_linkspeed_result == LS_DEGRADE) ? SUB_SPEEDIDLE : SUB_REPAIR;
            end
          end else if (expired) state_d = ST_ERROR;
        ST_GAP: state_d = ST_ACTIVE;
        default: state_d = state_q;
      endcase
    end
    sub_en_d = (state_d == ST_ACTIVE) ? {{(NUM_SUBSTATES-1){1'b0}}, 1'b1} << idx_d : '0;
    done_d = state_d == ST_DONE;
    error_d = state_d == ST_ERROR;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      rt_q <= '0;
      sub_en_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rt_q <= rt_d;
      sub_en_q <= sub_en_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  assign o_sub_en = sub_en_q;
  assign o_substate = idx_q;
  assign o_done = done_q;
  assign o_error = error_q;
endmodule

// File: tb/tb_mbtrain_seq_ctrl.sv
// tb_mbtrain_seq_ctrl: directed checks of MBTRAIN sequencing, LINKSPEED loops, timeout, abort and reset.
module tb_mbtrain_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_en = 1'b0;
  logic [12:0] i_sub_ack = '0;
  logic [1:0] i_linkspeed_result = 2'b00;
  logic [12:0] o_sub_en;
  logic [3:0] o_substate;
  logic o_done, o_error;
  int n_cmp = 0;
  int n_err = 0;
  mbtrain_seq_ctrl #(.TIMEOUT_CYCLES(16), .MAX_RETRAIN(3)) dut (
    .clk(clk),
    .rst(rst),
    .i_en(i_en),
    .i_sub_ack(i_sub_ack),
    .i_linkspeed_result(i_linkspeed_result),
    .o_sub_en(o_sub_en),
    .o_substate(o_substate),
    .o_done(o_done),
    .o_error(o_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic do_sub(input int idx);
    logic [12:0] e;
    e = 13'd1 << idx;
    check($sformatf("sub_en[%0d]", idx), 32'(o_sub_en), 32'(e));
    check($sformatf("substate[%0d]", idx), 32'(o_substate), idx);
    repeat (2) step();
    i_sub_ack = e;
    step();
    i_sub_ack = '0;
  endtask
  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      do_sub(i);
      check("gap", 32'(o_sub_en), 0);
      step();
    end
  endtask
  task automatic start();
    i_en = 1'b1;
    step();
  endtask
  task automatic stop();
    i_en = 1'b0;
    step();
    check("stop_clear", {o_sub_en, o_substate, o_done, o_error}, 0);
  endtask
  initial begin
    step();
    check("rst_outputs", {o_sub_en, o_substate, o_done, o_error}, 0);
    rst = 1'b0;
    step();
    check("idle_outputs", {o_sub_en, o_substate, o_done, o_error}, 0);
    // nominal pass, with a stray ack on a non-enabled substate first
    start();
    i_sub_ack = 13'h020;
    step();
    i_sub_ack = '0;
    check("stray_ack_ignored", 32'(o_sub_en), 32'h001);
    run_range(0, 10);
    i_linkspeed_result = 2'b00;
    do_sub(11);
    check("nom_done", {o_sub_en, o_done, o_error}, 2);
    step();
    check("done_sticky", o_done, 1);
    stop();
    // speed degrade loop then pass
    start();
    run_range(0, 10);
    i_linkspeed_result = 2'b01;
    do_sub(11);
    check("deg_gap", {o_sub_en, o_done, o_error}, 0);
    step();
    run_range(2, 10);
    i_linkspeed_result = 2'b00;
    do_sub(11);
    check("deg_done", {o_done, o_error}, 2);
    stop();
    // repair path and retrain limit
    start();
    run_range(0, 10);
    i_linkspeed_result = 2'b10;
    do_sub(11);
    check("rep_gap", 32'(o_sub_en), 0);
    step();
    run_range(12, 12);
    check("rep_to_txselfcal", 32'(o_sub_en), 32'h008);
    run_range(3, 10);
    do_sub(11);
    step();
    run_range(12, 12);
    run_range(3, 10);
    i_linkspeed_result = 2'b01;
    do_sub(11);
    step();
    run_range(2, 10);
    i_linkspeed_result = 2'b10;
    do_sub(11);
    check("limit_error", {o_sub_en, o_done, o_error}, 1);
    step();
    check("error_sticky", o_error, 1);
    stop();
    // LINKSPEED fail result
    start();
    run_range(0, 10);
    i_linkspeed_result = 2'b11;
    do_sub(11);
    check("fail_error", {o_sub_en, o_done, o_error}, 1);
    stop();
    // timeout behaviour on substate 4
    start();
    run_range(0, 3);
    check("to_en4", 32'(o_sub_en), 32'h010);
`ifdef MBTRAIN_TIMEOUT_EN
    repeat (15) step();
    check("to_before_expiry", o_error, 0);
    step();
    check("to_expired", {o_sub_en, o_done, o_error}, 1);
    stop();
    start();
    run_range(0, 3);
    repeat (15) step();
    i_sub_ack = 13'h010;
    step();
    i_sub_ack = '0;
    check("to_ack_wins", {o_sub_en, o_error}, 0);
    step();
    check("to_ack_next", 32'(o_sub_en), 32'h020);
`else
    repeat (1000) step();
    check("no_to_error", o_error, 0);
    check("no_to_still_en", 32'(o_sub_en), 32'h010);
`endif
    stop();
    // abort with retrain count at its limit, then restart clears it
    start();
    i_linkspeed_result = 2'b01;
    run_range(0, 10);
    do_sub(11);
    step();
    for (int k = 0; k < 2; k++) begin
      run_range(2, 10);
      do_sub(11);
      step();
    end
    run_range(2, 6);
    check("abort_en7", 32'(o_sub_en), 32'h080);
    i_en = 1'b0;
    step();
    check("abort_clear", {o_sub_en, o_substate, o_done, o_error}, 0);
    start();
    run_range(0, 10);
    do_sub(11);
    check("restart_no_error", {o_sub_en, o_error}, 0);
    step();
    check("restart_degrade", 32'(o_sub_en), 32'h004);
    stop();
    // asynchronous reset while substate 6 is active
    start();
    run_range(0, 5);
    check("rst_en6", 32'(o_sub_en), 32'h040);
    #2 rst = 1'b1;
    #1 check("async_rst", {o_sub_en, o_substate, o_done, o_error}, 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_start", 32'(o_sub_en), 32'h001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
